// File: rtl/tx_phase_pkg.sv
// rtl/tx_phase_pkg.sv - shared widths, types and constants for tx_phase_comps
package tx_phase_pkg;

    localparam int DW   = 16;   // sample width
    localparam int CW   = 16;   // coefficient component width
    localparam int PW   = 33;   // product-sum width
    localparam int FRAC = 15;   // Q1.15 fraction bits

    // Imaginary part in the upper half so a coefficient word {imag, real}
    // casts straight onto this type.
    typedef struct packed {
        logic signed [DW-1:0] im;
        logic signed [DW-1:0] re;
    } cplx16_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

    // 1.0 + j0 in Q1.15
    localparam logic [2*CW-1:0] COEF_UNITY = 32'h0000_7FFF;

    // Sideband that travels alongside each beat through the pipeline
    typedef struct packed {
        logic       valid;
        logic       sop;
        logic       eop;
        logic [3:0] sym;
        logic [7:0] slot;
    } side_t;

endpackage

// File: rtl/cmult_rnd.sv
// rtl/cmult_rnd.sv - 3-stage complex multiply with round-half-up and 16-bit reduction
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   a          : sample (registered upstream, stage S1)
//   c          : Q1.15 coefficient (registered upstream, stage S1)
//   y          : rounded, reduced product, valid three cycles after a/c
//
// Macro TX_PHASE_SAT_EN: saturate to [-32768, 32767]; otherwise wrap to 16 bits.
module cmult_rnd
    import tx_phase_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  cplx16_t a,
    input  cplx16_t c,
    output cplx16_t y
);

    localparam logic [PW:0]             HALF  = (PW+1)'(1) << (FRAC-1);
    localparam logic signed [PW-FRAC:0] Q_MAX = (PW-FRAC+1)'(2**(DW-1) - 1);
    localparam logic signed [PW-FRAC:0] Q_MIN = ~Q_MAX;

    logic signed [DW+CW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW-1:0]    sum_re, sum_im;

    // Round half-up, then drop FRAC bits and reduce to DW bits.
    function automatic logic [DW-1:0] reduce(input logic signed [PW-1:0] s);
        logic signed [PW:0]      rnd;
        logic signed [PW-FRAC:0] q;
        rnd = {s[PW-1], s} + HALF;
        q   = rnd[PW:FRAC];
`ifdef TX_PHASE_SAT_EN
        if (q > Q_MAX)
            return Q_MAX[DW-1:0];
        else if (q < Q_MIN)
            return Q_MIN[DW-1:0];
        else
            return q[DW-1:0];
`else
        return q[DW-1:0];
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr   <= '0;
            p_ii   <= '0;
            p_ri   <= '0;
            p_ir   <= '0;
            sum_re <= '0;
            sum_im <= '0;
            y      <= '0;
        end else begin
            // S2: four 16x16 products
            p_rr <= $signed(a.re) * $signed(c.re);
            p_ii <= $signed(a.im) * $signed(c.im);
            p_ri <= $signed(a.re) * $signed(c.im);
            p_ir <= $signed(a.im) * $signed(c.re);
            // S3: sign-extend to PW and combine
            sum_re <= {p_rr[DW+CW-1], p_rr} - {p_ii[DW+CW-1], p_ii};
            sum_im <= {p_ri[DW+CW-1], p_ri} + {p_ir[DW+CW-1], p_ir};
            // S4: round and reduce
            y.re <= reduce(sum_re);
            y.im <= reduce(sum_im);
        end
    end

endmodule

// File: rtl/tx_phase_comps.sv
// rtl/tx_phase_comps.sv - TX per-symbol phase pre-compensation (framing, counters, coefficient latch)
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   frame_sync                     : next sop is symbol 0 of slot 0
//   din_valid/sop/eop/real/imag    : framed IQ input, no backpressure
//   coef_data[COEF_NUM]            : {imag, real} Q1.15 coefficient bank
//   dout_valid/sop/eop/real/imag   : compensated IQ, 4 cycles after input
//   dout_symbol, dout_slot         : indices the beat was tagged with on entry
//   proto_err                      : one-cycle pulse, one cycle after a framing violation
//
// Macro TX_PHASE_SAT_EN (applied in cmult_rnd): saturate instead of wrap.
module tx_phase_comps
    import tx_phase_pkg::*;
#(
    parameter int COEF_NUM = 28,
    parameter int SYM_NUM  = 14,
    parameter int SLOT_NUM = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_sync,
    input  logic        din_valid,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic [15:0] din_real,
    input  logic [15:0] din_imag,
    input  logic [31:0] coef_data [COEF_NUM-1:0],
    output logic        dout_valid,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [15:0] dout_real,
    output logic [15:0] dout_imag,
    output logic [3:0]  dout_symbol,
    output logic [7:0]  dout_slot,
    output logic        proto_err
);

    frame_state_t state, base_state, state_nxt;
    logic [3:0]   sym_cnt, base_sym, cur_sym, sym_nxt;
    logic [7:0]   slot_cnt, base_slot, cur_slot, slot_nxt;
    logic         beat_sop, implicit_eop, fwd, err_nxt;
    logic [7:0]   coef_idx;
    logic [31:0]  coef_sel;
    side_t        side_in;
    side_t        side_q [4];
    cplx16_t      s1_a, s1_c, mult_y;

    // Next symbol/slot position after a symbol end: returns {slot, sym}.
    function automatic logic [11:0] advance(input logic [3:0] sym, input logic [7:0] slot);
        logic [3:0] s;
        logic [7:0] l;
        l = slot;
        if (sym == 4'(SYM_NUM - 1)) begin
            s = '0;
            l = (slot == 8'(SLOT_NUM - 1)) ? '0 : slot + 8'd1;
        end else begin
            s = sym + 4'd1;
        end
        return {l, s};
    endfunction

    always_comb begin
        // frame_sync takes effect on the beat it arrives with
        base_state = frame_sync ? IDLE : state;
        base_sym   = frame_sync ? '0 : sym_cnt;
        base_slot  = frame_sync ? '0 : slot_cnt;

        beat_sop     = din_valid & din_sop;
        // sop inside a symbol closes the previous one first
        implicit_eop = beat_sop & (base_state == ACTIVE);
        if (implicit_eop)
            {cur_slot, cur_sym} = advance(base_sym, base_slot);
        else
            {cur_slot, cur_sym} = {base_slot, base_sym};

        fwd     = din_valid & ((base_state == ACTIVE) | din_sop);
        err_nxt = din_valid & (((base_state == IDLE) & ~din_sop) | implicit_eop);

        state_nxt = base_state;
        if (beat_sop & ~din_eop)
            state_nxt = ACTIVE;
        else if (fwd & din_eop)
            state_nxt = IDLE;

        if (fwd & din_eop)
            {slot_nxt, sym_nxt} = advance(cur_sym, cur_slot);
        else
            {slot_nxt, sym_nxt} = {cur_slot, cur_sym};

        // Slot 0 uses the first SYM_NUM entries, every other slot the next SYM_NUM.
        coef_idx = {4'd0, cur_sym} + ((cur_slot != '0) ? 8'(SYM_NUM) : 8'd0);
        coef_sel = COEF_UNITY;
        for (int i = 0; i < COEF_NUM; i++) begin
            if (coef_idx == 8'(i))
                coef_sel = coef_data[i];
        end

        side_in.valid = fwd;
        side_in.sop   = fwd & din_sop;
        side_in.eop   = fwd & din_eop;
        side_in.sym   = cur_sym;
        side_in.slot  = cur_slot;
    end

    // S1: framing FSM, counters, input register, coefficient latch, sideband delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sym_cnt   <= '0;
            slot_cnt  <= '0;
            proto_err <= 1'b0;
            s1_a      <= '0;
            s1_c      <= '0;
            for (int i = 0; i < 4; i++)
                side_q[i] <= '0;
        end else begin
            state     <= state_nxt;
            sym_cnt   <= sym_nxt;
            slot_cnt  <= slot_nxt;
            proto_err <= err_nxt;
            if (fwd)
                s1_a <= cplx16_t'({din_imag, din_real});
            // coefficient is held for the whole symbol
            if (fwd & din_sop)
                s1_c <= cplx16_t'(coef_sel);
            side_q[0] <= side_in;
            for (int i = 1; i < 4; i++)
                side_q[i] <= side_q[i-1];
        end
    end

    cmult_rnd u_cmult (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (s1_a),
        .c     (s1_c),
        .y     (mult_y)
    );

    assign dout_valid  = side_q[3].valid;
    assign dout_sop    = side_q[3].sop;
    assign dout_eop    = side_q[3].eop;
    assign dout_symbol = side_q[3].sym;
    assign dout_slot   = side_q[3].slot;
    assign dout_real   = mult_y.re;
    assign dout_imag   = mult_y.im;

endmodule

// File: tb/tb_tx_phase_comps.sv
// tb/tb_tx_phase_comps.sv - self-checking bench for tx_phase_comps
module tb_tx_phase_comps;

    logic        clk = 1'b0;
    logic        rst_n, frame_sync, din_valid, din_sop, din_eop;
    logic [15:0] din_real, din_imag;
    logic [31:0] coef [27:0];
    logic        dout_valid, dout_sop, dout_eop, proto_err;
    logic [15:0] dout_real, dout_imag;
    logic [3:0]  dout_symbol;
    logic [7:0]  dout_slot;

    tx_phase_comps dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_sync  (frame_sync),
        .din_valid   (din_valid),
        .din_sop     (din_sop),
        .din_eop     (din_eop),
        .din_real    (din_real),
        .din_imag    (din_imag),
        .coef_data   (coef),
        .dout_valid  (dout_valid),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .dout_real   (dout_real),
        .dout_imag   (dout_imag),
        .dout_symbol (dout_symbol),
        .dout_slot   (dout_slot),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        sop;
        logic        eop;
        logic [3:0]  sym;
        logic [7:0]  slot;
        logic [31:0] cyc;
    } beat_t;

    beat_t exp_q[$], obs_q[$];
    int    err_exp[$], err_obs[$];
    int    n_tests = 0, n_fail = 0;

    // reference model state
    bit          m_active;
    int          m_sym, m_slot;
    logic [31:0] m_coef;

    always @(negedge clk) begin
        if (dout_valid)
            obs_q.push_back('{re: dout_real, im: dout_imag, sop: dout_sop, eop: dout_eop,
                              sym: dout_symbol, slot: dout_slot, cyc: 32'(cyc)});
        if (proto_err)
            err_obs.push_back(cyc);
    end

    function automatic string fmt(input beat_t b);
        return $sformatf("re=%0d im=%0d sop=%0b eop=%0b sym=%0d slot=%0d cyc=%0d",
                         $signed(b.re), $signed(b.im), b.sop, b.eop, b.sym, b.slot, b.cyc);
    endfunction

    function automatic logic [15:0] reduce_ref(input longint p);
        longint r;
        r = (p + 16384) >>> 15;
`ifdef TX_PHASE_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_sym    = 0;
        m_slot   = 0;
    endtask

    task automatic model_advance();
        m_sym++;
        if (m_sym == 14) begin
            m_sym  = 0;
            m_slot = (m_slot + 1) % 20;
        end
    endtask

    task automatic model_beat(input bit fs, v, sop, eop, input logic [15:0] re, im);
        int     idx;
        longint ar, ai, cr, ci;
        if (fs) model_reset();
        if (!v) return;
        if (!m_active && !sop) begin
            err_exp.push_back(cyc + 1);
            return;
        end
        if (sop) begin
            if (m_active) begin
                err_exp.push_back(cyc + 1);
                model_advance();
            end
            idx      = m_sym + ((m_slot != 0) ? 14 : 0);
            m_coef   = (idx < 28) ? coef[idx] : 32'h0000_7FFF;
            m_active = 1;
        end
        ar = $signed(re);
        ai = $signed(im);
        cr = $signed(m_coef[15:0]);
        ci = $signed(m_coef[31:16]);
        exp_q.push_back('{re: reduce_ref(ar * cr - ai * ci), im: reduce_ref(ar * ci + ai * cr),
                          sop: sop, eop: eop, sym: m_sym[3:0], slot: m_slot[7:0], cyc: 32'(cyc + 4)});
        if (eop) begin
            m_active = 0;
            model_advance();
        end
    endtask

    task automatic drive(input bit fs, v, sop, eop, input logic [15:0] re, im);
        @(negedge clk);
        frame_sync = fs;
        din_valid  = v;
        din_sop    = sop;
        din_eop    = eop;
        din_real   = re;
        din_imag   = im;
        model_beat(fs, v, sop, eop, re, im);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 16'd0, 16'd0);
    endtask

    // Changes land just after a sampling edge so drive/model see them together.
    task automatic set_coef(input int i, input logic [31:0] v);
        @(posedge clk);
        #1;
        coef[i] = v;
    endtask

    task automatic load_all(input bit rnd);
        @(posedge clk);
        #1;
        for (int i = 0; i < 28; i++)
            coef[i] = rnd ? $urandom : 32'h0000_7FFF;
    endtask

    task automatic send_symbol(input int len, input bit fs);
        for (int b = 0; b < len; b++) begin
            if (b != 0 && $urandom_range(3) == 0) idle(1);
            drive(fs && b == 0, 1, b == 0, b == len - 1, 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic clear_queues();
        obs_q.delete();
        exp_q.delete();
        err_obs.delete();
        err_exp.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({dout_valid, dout_sop, dout_eop, proto_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {dout_valid, dout_sop, dout_eop, proto_err});
        end
        n_tests++;
        if ({dout_real, dout_imag} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", {dout_real, dout_imag});
        end
        n_tests++;
        if ({dout_symbol, dout_slot} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_index got %h want 0", {dout_symbol, dout_slot});
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        n_tests++;
        if (obs_q.size() != 0 || err_obs.size() != 0) begin
            n_fail++;
            $display("FAIL reset_quiet got beats=%0d errs=%0d want 0 0", obs_q.size(), err_obs.size());
        end
    endtask

    task automatic test_arith();
        int          t0;
        logic [15:0] want_sat;
        clear_queues();
        load_all(0);
        drive(1, 1, 1, 1, 16'd1000, 16'(-2000));
        t0 = cyc;
        set_coef(0, 32'h7FFF_0000);
        drive(1, 1, 1, 1, 16'd1000, 16'(-2000));
        set_coef(0, 32'h0000_8000);
        drive(1, 1, 1, 1, 16'h8000, 16'h8000);
        for (int s = 0; s < 6; s++) begin
            set_coef(0, $urandom);
            drive(1, 1, 1, 0, 16'($urandom), 16'($urandom));
            drive(0, 1, 0, 0, 16'($urandom), 16'($urandom));
            set_coef(0, $urandom);
            drive(0, 1, 0, 1, 16'($urandom), 16'($urandom));
        end
        idle(8);
        n_tests++;
        if (obs_q[0] !== beat_t'{16'd1000, 16'(-2000), 1'b1, 1'b1, 4'd0, 8'd0, 32'(t0 + 4)}) begin
            n_fail++;
            $display("FAIL arith_unity got %s want re=1000 im=-2000 sop=1 eop=1 cyc=%0d", fmt(obs_q[0]), t0 + 4);
        end
        n_tests++;
        if (obs_q[1].re !== 16'd2000 || obs_q[1].im !== 16'd1000) begin
            n_fail++;
            $display("FAIL arith_j got %s want re=2000 im=1000", fmt(obs_q[1]));
        end
`ifdef TX_PHASE_SAT_EN
        want_sat = 16'h7FFF;
`else
        want_sat = 16'h8000;
`endif
        n_tests++;
        if (obs_q[2].re !== want_sat || obs_q[2].im !== want_sat) begin
            n_fail++;
            $display("FAIL arith_limit got %s want re=im=%0d", fmt(obs_q[2]), $signed(want_sat));
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL arith_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL arith_beat[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_counter_wrap();
        int k;
        clear_queues();
        load_all(1);
        send_symbol(3, 1);
        for (int s = 1; s < 14 * 20 + 1; s++)
            send_symbol(3, 0);
        idle(8);
        k = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].sop) begin
                n_tests++;
                if (obs_q[i].sym !== 4'(k % 14) || obs_q[i].slot !== 8'((k / 14) % 20)) begin
                    n_fail++;
                    $display("FAIL wrap_index[%0d] got sym=%0d slot=%0d want sym=%0d slot=%0d",
                             k, obs_q[i].sym, obs_q[i].slot, k % 14, (k / 14) % 20);
                end
                k++;
            end
        end
        n_tests++;
        if (k != 281) begin
            n_fail++;
            $display("FAIL wrap_symbols got %0d want 281", k);
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_beat[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_protocol();
        clear_queues();
        load_all(0);
        set_coef(1, 32'h7FFF_0000);
        drive(0, 1, 0, 0, 16'd5, 16'd6);
        drive(0, 1, 0, 1, 16'd7, 16'd8);
        drive(1, 1, 1, 0, 16'd1, 16'd2);
        drive(0, 1, 0, 0, 16'd1000, 16'(-2000));
        drive(0, 1, 1, 0, 16'd3, 16'd4);
        drive(0, 1, 0, 0, 16'd1000, 16'(-2000));
        drive(0, 1, 0, 1, 16'd9, 16'd9);
        idle(6);
        n_tests++;
        if (obs_q.size() != 5 || err_obs.size() != 3) begin
            n_fail++;
            $display("FAIL proto_counts got beats=%0d errs=%0d want 5 3", obs_q.size(), err_obs.size());
        end
        n_tests++;
        if (obs_q[1].eop !== 1'b0 || obs_q[1].re !== 16'd1000 || obs_q[1].im !== 16'(-2000)) begin
            n_fail++;
            $display("FAIL proto_prev_tail got %s want re=1000 im=-2000 eop=0", fmt(obs_q[1]));
        end
        n_tests++;
        if (obs_q[2].sop !== 1'b1 || obs_q[2].sym !== 4'd1 || obs_q[3].re !== 16'd2000 || obs_q[3].im !== 16'd1000) begin
            n_fail++;
            $display("FAIL proto_implicit got %s / %s want sop=1 sym=1 then re=2000 im=1000",
                     fmt(obs_q[2]), fmt(obs_q[3]));
        end
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(15) == 0) set_coef($urandom_range(27), $urandom);
            drive($urandom_range(31) == 0, $urandom_range(9) < 7, $urandom_range(3) == 0,
                  $urandom_range(3) == 0, 16'($urandom), 16'($urandom));
        end
        idle(8);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL proto_beat_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL proto_beat[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        n_tests++;
        if (err_obs.size() != err_exp.size()) begin
            n_fail++;
            $display("FAIL proto_err_count got %0d want %0d", err_obs.size(), err_exp.size());
        end
        for (int i = 0; i < err_obs.size() && i < err_exp.size(); i++) begin
            n_tests++;
            if (err_obs[i] !== err_exp[i]) begin
                n_fail++;
                $display("FAIL proto_err[%0d] got cyc=%0d want cyc=%0d", i, err_obs[i], err_exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_queues();
        load_all(1);
        send_symbol(2, 1);
        send_symbol(2, 0);
        send_symbol(2, 0);
        idle(6);
        drive(0, 1, 1, 0, 16'($urandom), 16'($urandom));
        drive(0, 1, 0, 0, 16'($urandom), 16'($urandom));
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        model_reset();
        while (exp_q.size() > 0 && exp_q[$].cyc > 32'(cyc))
            void'(exp_q.pop_back());
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        n = exp_q.size();
        drive(1, 1, 1, 0, 16'($urandom), 16'($urandom));
        drive(0, 1, 0, 0, 16'($urandom), 16'($urandom));
        drive(0, 1, 0, 1, 16'($urandom), 16'($urandom));
        idle(8);
        n_tests++;
        if (obs_q.size() != n + 3) begin
            n_fail++;
            $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), n + 3);
        end
        n_tests++;
        if (obs_q[n].sop !== 1'b1 || obs_q[n].sym !== 4'd0 || obs_q[n].slot !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_first got %s want sop=1 sym=0 slot=0", fmt(obs_q[n]));
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_beat[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_sync = 1'b0;
        din_valid  = 1'b0;
        din_sop    = 1'b0;
        din_eop    = 1'b0;
        din_real   = '0;
        din_imag   = '0;
        for (int i = 0; i < 28; i++) coef[i] = 32'h0000_7FFF;
        model_reset();
        test_reset();
        test_arith();
        test_counter_wrap();
        test_protocol();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
